// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for a free-running counter.
// Clears the counter, enables it until it reaches a latched terminal value,
// then emits a tick (and a done pulse in one-shot mode). Continuous mode
// re-clears and repeats, giving a tick every period+2 cycles.
module counter_ctrl #(
    parameter int WIDTH = 26,
    parameter int TCW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_resetn,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [TCW-1:0]   tick_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] period_r;
    logic             mode_r;
    logic             tick_r;
    logic [TCW-1:0]   tick_count_r;
    logic             accept_s;
    logic             terminal_s;

    // Next-state and decoded outputs; stop overrides everything outside IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        terminal_s   = 1'b0;
        cnt_en       = 1'b0;
        cnt_resetn   = ~reset;
        done         = 1'b0;
        busy         = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !stop) begin
                    accept_s     = 1'b1;
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (stop) begin
                    // an aborted run leaves the counter value untouched
                    state_next_s = IDLE;
                end else begin
                    cnt_resetn   = 1'b0;
                    state_next_s = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (stop) begin
                    // enable is dropped so the counter freezes on the stop cycle
                    state_next_s = IDLE;
                end else begin
                    cnt_en = (count != period_r);
                    if (count == period_r) begin
                        terminal_s   = 1'b1;
                        state_next_s = mode_r ? DONE : CLEAR;
                    end else begin
                        state_next_s = RUN;
                    end
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Terminal value and mode are captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_r <= {WIDTH{1'b0}};
            mode_r   <= 1'b0;
        end else if (accept_s) begin
            period_r <= period;
            mode_r   <= oneshot;
        end else begin
            period_r <= period_r;
            mode_r   <= mode_r;
        end
    end

    // Tick pulse and wrapping tick accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r       <= 1'b0;
            tick_count_r <= {TCW{1'b0}};
        end else begin
            tick_r <= terminal_s;
            if (accept_s) begin
                tick_count_r <= {TCW{1'b0}};
            end else if (terminal_s) begin
                tick_count_r <= tick_count_r + TCW'(1);
            end else begin
                tick_count_r <= tick_count_r;
            end
        end
    end

    assign tick       = tick_r;
    assign tick_count = tick_count_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural model of the counter.
module tb_counter_ctrl;

    localparam int WIDTH = 26;
    localparam int TCW   = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             oneshot;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             cnt_resetn;
    logic             tick;
    logic             done;
    logic             busy;
    logic [TCW-1:0]   tick_count;

    int checks = 0;
    int errors = 0;

    counter_ctrl #(.WIDTH(WIDTH), .TCW(TCW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .oneshot    (oneshot),
        .period     (period),
        .count      (count),
        .cnt_en     (cnt_en),
        .cnt_resetn (cnt_resetn),
        .tick       (tick),
        .done       (done),
        .busy       (busy),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter block model: synchronous active-low clear, count when enabled.
    always_ff @(posedge clk) begin
        if (!cnt_resetn) begin
            count <= '0;
        end else if (cnt_en) begin
            count <= count + 26'd1;
        end else begin
            count <= count;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        oneshot = 1'b0;
        period  = 26'd0;

        // ---- 1: reset, then continuous period 4 ----
        step();
        step();
        check("rst_cnt_resetn", 32'(cnt_resetn), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_cnt_en",     32'(cnt_en),     32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_tick",       32'(tick),       32'd0);
        check("rst_tick_count", 32'(tick_count), 32'd0);
        check("rst_count",      32'(count),      32'd0);
        reset = 1'b0;
        #1;
        check("idle_cnt_resetn", 32'(cnt_resetn), 32'd1);

        period  = 26'd4;
        oneshot = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("t1_clear_busy",   32'(busy),       32'd1);
        check("t1_clear_resetn", 32'(cnt_resetn), 32'd0);
        check("t1_clear_en",     32'(cnt_en),     32'd0);
        for (int k = 1; k <= 19; k++) begin
            step();
            check("t1_tick", 32'(tick), 32'((k == 6) || (k == 12) || (k == 18)));
            check("t1_busy", 32'(busy), 32'd1);
            if (k == 6) begin
                check("t1_tc1",   32'(tick_count), 32'd1);
                check("t1_count", 32'(count),      32'd4);
            end else if (k == 12) begin
                check("t1_tc2", 32'(tick_count), 32'd2);
            end else if (k == 18) begin
                check("t1_tc3", 32'(tick_count), 32'd3);
            end else begin
                check("t1_done", 32'(done), 32'd0);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t1_stop_busy", 32'(busy),       32'd0);
        check("t1_stop_tc",   32'(tick_count), 32'd3);

        // ---- 2: one-shot period 3 ----
        period  = 26'd3;
        oneshot = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        period  = 26'd7;
        oneshot = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t2_tick", 32'(tick), 32'(k == 5));
            check("t2_done", 32'(done), 32'(k == 5));
        end
        check("t2_count_hold", 32'(count),      32'd3);
        check("t2_tc",         32'(tick_count), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2_idle_busy", 32'(busy), 32'd0);
        check("t2_idle_done", 32'(done), 32'd0);
        check("t2_idle_tick", 32'(tick), 32'd0);
        step();
        check("t2_ignored_busy", 32'(busy),  32'd0);
        check("t2_ignored_cnt",  32'(count), 32'd3);

        // ---- 3: stop mid-run, then restart ----
        period  = 26'd10;
        oneshot = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("t3_tc_cleared", 32'(tick_count), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
        end
        check("t3_count2", 32'(count), 32'd2);
        stop = 1'b1;
        #1;
        check("t3_stop_en", 32'(cnt_en), 32'd0);
        step();
        stop = 1'b0;
        check("t3_busy",  32'(busy),   32'd0);
        check("t3_en",    32'(cnt_en), 32'd0);
        check("t3_count", 32'(count),  32'd2);
        check("t3_tick",  32'(tick),   32'd0);
        step();
        check("t3_count_hold", 32'(count), 32'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_re_tc",    32'(tick_count), 32'd0);
        check("t3_re_count", 32'(count),      32'd2);
        step();
        check("t3_re_cleared", 32'(count), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // ---- 4: period 0, tick every 2 cycles, accumulator wraps ----
        period = 26'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 514; k++) begin
            step();
            check("t4_tick", 32'(tick),       32'((k % 2) == 0));
            check("t4_tc",   32'(tick_count), 32'((k / 2) % 256));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_stop_busy", 32'(busy), 32'd0);

        // ---- 5: start+stop in IDLE; start during RUN ignored ----
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t5_both_busy", 32'(busy), 32'd0);
        period = 26'd4;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            check("t5_tick", 32'(tick), 32'((k == 6) || (k == 12)));
            if (k == 3) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("t5_tc", 32'(tick_count), 32'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // ---- 6: reset mid-run at count 5 ----
        period = 26'd9;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
        end
        check("t6_count5", 32'(count), 32'd5);
        check("t6_busy",   32'(busy),  32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_resetn", 32'(cnt_resetn), 32'd0);
        step();
        check("t6_count",      32'(count),      32'd0);
        check("t6_tick",       32'(tick),       32'd0);
        check("t6_tc",         32'(tick_count), 32'd0);
        check("t6_busy_after", 32'(busy),       32'd0);
        check("t6_en",         32'(cnt_en),     32'd0);
        reset = 1'b0;
        #1;
        check("t6_resetn_rel", 32'(cnt_resetn), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
